// File: rtl/sum_frame_accumulator.sv
// Sums BEATS {carry,sum} adder results into an ACC_W-bit frame total.
// Define SUM_ACC_SATURATE_EN to clamp the total at all ones on overflow.
module sum_frame_accumulator #(
    parameter int ACC_W = 12,
    parameter int BEATS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [7:0]       beat_cnt
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [7:0]       cnt;
    logic             accept;
    logic             take;
    logic             last_beat;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_add;

    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign last_beat = (cnt == 8'(BEATS - 1));
    assign sum       = {1'b0, acc} + {{(ACC_W - 4){1'b0}}, in_carry, in_sum};

`ifdef SUM_ACC_SATURATE_EN
    // Once clamped, stay clamped until the frame ends.
    assign acc_add = (sum[ACC_W] || ovf) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ACCUM;
        end else begin
            unique case (state)
                ACCUM: if (accept && last_beat) state_nxt = DONE;
                DONE:  if (take) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (clr || take) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_add;
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt + 8'd1;
        end
    end

    assign out_acc  = acc;
    assign out_ovf  = ovf;
    assign beat_cnt = cnt;

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Randomized bench for sum_frame_accumulator: 12-bit, 7-bit and 1-beat
// instances checked against a whole-frame arithmetic model.
module tb_sum_frame_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_sum = '0;
    logic        in_carry = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_acc;
    logic        out_ovf;
    logic [7:0]  beat_cnt;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [6:0]  w_out_acc;
    logic        w_out_ovf;
    logic [7:0]  w_beat_cnt;

    logic        b_in_valid = 1'b0;
    logic [3:0]  b_in_sum = '0;
    logic        b_in_carry = 1'b0;
    logic        b_out_ready = 1'b0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [11:0] b_out_acc;
    logic        b_out_ovf;
    logic [7:0]  b_beat_cnt;

    int checks = 0;
    int errors = 0;
    int frame[8];

    always #5 clk = ~clk;

    sum_frame_accumulator #(.ACC_W(12), .BEATS(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf), .beat_cnt(beat_cnt)
    );

    sum_frame_accumulator #(.ACC_W(7), .BEATS(8)) u_w7 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_sum(in_sum), .in_carry(in_carry),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_acc(w_out_acc), .out_ovf(w_out_ovf), .beat_cnt(w_beat_cnt)
    );

    sum_frame_accumulator #(.ACC_W(12), .BEATS(1)) u_b1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sum(b_in_sum), .in_carry(b_in_carry),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_acc(b_out_acc), .out_ovf(b_out_ovf), .beat_cnt(b_beat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_acc(input int total, input int w);
        int lim;
        lim = 1 << w;
`ifdef SUM_ACC_SATURATE_EN
        return (total >= lim) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    function automatic int exp_ovf(input int total, input int w);
        return (total >= (1 << w)) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int v);
        repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_sum = 4'($urandom);
            tick();
        end
        in_valid = 1'b1;
        {in_carry, in_sum} = 5'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(output int total);
        total = 0;
        for (int i = 0; i < 8; i++) begin
            chk("acc_cnt", beat_cnt, i);
            chk("acc_valid", out_valid, 0);
            chk("acc_ready", in_ready, 1);
            send_beat(frame[i]);
            total += frame[i];
        end
    endtask

    task automatic check_done(input int total);
        chk("done_valid", out_valid, 1);
        chk("done_ready", in_ready, 0);
        chk("done_cnt", beat_cnt, 8);
        chk("done_acc", out_acc, exp_acc(total, 12));
        chk("done_ovf", out_ovf, exp_ovf(total, 12));
        chk("w7_valid", w_out_valid, 1);
        chk("w7_acc", w_out_acc, exp_acc(total, 7));
        chk("w7_ovf", w_out_ovf, exp_ovf(total, 7));
    endtask

    task automatic drain(input int total, input int bp);
        out_ready = 1'b0;
        repeat (bp) begin
            in_valid = 1'($urandom);
            in_sum = 4'h3;
            in_carry = 1'b0;
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_cnt", beat_cnt, 8);
            chk("bp_acc", out_acc, exp_acc(total, 12));
            chk("bp_w7acc", w_out_acc, exp_acc(total, 7));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
        chk("post_acc", out_acc, 0);
        chk("post_ovf", w_out_ovf, 0);
        chk("post_cnt", beat_cnt, 0);
    endtask

    initial begin
        int total;

        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_acc", out_acc, 0);
        chk("rst_cnt", beat_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset mid-frame after three beats
        for (int i = 0; i < 3; i++) send_beat(1);
        chk("pre_rst_cnt", beat_cnt, 3);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_cnt", beat_cnt, 0);
        chk("arst_acc", out_acc, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) frame[i] = 1;
        send_frame(total);
        check_done(total);
        chk("ones_acc", out_acc, 8);
        drain(total, 1);

        // All-31 frame with backpressure
        for (int i = 0; i < 8; i++) frame[i] = 31;
        send_frame(total);
        check_done(total);
        chk("max_acc", out_acc, 248);
        drain(total, 5);

        // clr collides with a beat
        send_beat(5);
        send_beat(7);
        send_beat(9);
        chk("clr_pre_acc", out_acc, 21);
        clr = 1'b1;
        in_valid = 1'b1;
        {in_carry, in_sum} = 5'd4;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", beat_cnt, 0);
        chk("clr_acc", out_acc, 0);
        for (int i = 0; i < 8; i++) frame[i] = 2;
        send_frame(total);
        check_done(total);

        // clr collides with the output handshake
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        chk("clrhs_valid", out_valid, 0);
        chk("clrhs_acc", out_acc, 0);
        chk("clrhs_cnt", beat_cnt, 0);

        // clr while DONE without handshake
        for (int i = 0; i < 8; i++) frame[i] = 31;
        send_frame(total);
        check_done(total);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrdone_valid", out_valid, 0);
        chk("clrdone_ovf", w_out_ovf, 0);

        // Random frames
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 8; i++) frame[i] = $urandom_range(0, 31);
            send_frame(total);
            check_done(total);
            drain(total, $urandom_range(0, 4));
        end

        // Single-beat frames
        b_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            int v;
            case (k)
                0: v = 0;
                1: v = 31;
                2: v = 16;
                default: v = $urandom_range(0, 31);
            endcase
            chk("b1_ready", b_in_ready, 1);
            b_in_valid = 1'b1;
            {b_in_carry, b_in_sum} = 5'(v);
            tick();
            b_in_valid = 1'b0;
            chk("b1_valid", b_out_valid, 1);
            chk("b1_acc", b_out_acc, v);
            chk("b1_ovf", b_out_ovf, 0);
            chk("b1_cnt", b_beat_cnt, 1);
            tick();
            chk("b1_idle", b_out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_frame_accumulator.md
Name: sum_frame_accumulator

Overview:
- Downstream stage of the 4-bit adder. Consumes its 4-bit sum and carry-out once per accepted beat.
- Accumulates BEATS consecutive 5-bit results {carry,sum} into an ACC_W-bit total.
- Presents the total on a valid/ready output port.
- Flags overflow of the total, which is the frame-level equivalent of the adder's carry.

Parameters:
ACC_W, 12, accumulator/output width in bits; legal range 6..32.
BEATS, 8, adder results per frame; legal range 1..255.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous reset, active-high.
clr  input  1  synchronous frame abort; clears accumulator, count and overflow.
in_valid  input  1  adder result present this cycle.
in_ready  output  1  block accepts a beat this cycle.
in_sum  input  4  adder sum output.
in_carry  input  1  adder carry-out.
out_valid  output  1  frame total available.
out_ready  input  1  consumer takes the total.
out_acc  output  ACC_W  frame total.
out_ovf  output  1  total exceeded 2^ACC_W-1 during this frame.
beat_cnt  output  8  beats accepted in the current frame.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=ACCUM, acc=0, beat_cnt=0, ovf=0.
  - Outputs: out_valid=0, out_acc=0, out_ovf=0, in_ready=1.
  - Takes effect immediately, including mid-frame or while out_valid is high; any partial frame is discarded.
- Beat value: {in_carry,in_sum}, unsigned 0..31, zero-extended to ACC_W+1 bits before the add.
- Accept: in_valid && in_ready.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc + beat; beat_cnt++.
  - If the (ACC_W+1)-bit sum has its MSB set, ovf <= 1. ovf is sticky for the frame.
  - Default: acc keeps the low ACC_W bits, i.e. it wraps.
  - On accept with beat_cnt==BEATS-1: move to DONE next cycle with the updated acc/ovf.
  - Latency: out_valid rises the cycle after the last beat is accepted.
- State DONE:
  - in_ready=0; in_valid is ignored and no beat is dropped silently, because the producer must hold.
  - out_valid=1, out_acc=acc, out_ovf=ovf, all stable while out_ready=0.
  - On out_valid && out_ready: next cycle acc=0, ovf=0, beat_cnt=0, state=ACCUM.
  - The first beat of the next frame can be accepted one cycle after the output handshake. There is no same-cycle overlap.
- out_acc and out_ovf are driven from registers in both states. In ACCUM they show the running total; consumers qualify them with out_valid.
- clr:
  - In any state: next cycle acc=0, ovf=0, beat_cnt=0, state=ACCUM.
  - clr has priority over a simultaneous accept; that beat is discarded.
  - clr has priority over a simultaneous output handshake; the handshake still completes and the frame is consumed.
- BEATS=1: every accepted beat produces a frame; out_acc equals that beat value.
- beat_cnt never exceeds BEATS-1 in ACCUM and reads BEATS in DONE.

Optional Feature:
SUM_ACC_SATURATE_EN
- Defined: when an add overflows, acc is clamped to all ones (2^ACC_W-1) and stays there for the rest of the frame. ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W. ovf behaviour is identical in both cases.

Test Plan:
1. Reset: assert rst mid-frame after 3 beats -> same cycle out_valid=0, in_ready=1, beat_cnt=0; after release, a full 8-beat frame of value 1 gives out_acc=8.
2. Nominal (ACC_W=12, BEATS=8): 8 back-to-back beats {carry=1,sum=0xF} -> out_valid high the cycle after beat 8, out_acc=248, out_ovf=0, in_ready=0 in DONE.
3. Backpressure: hold out_ready=0 for 5 cycles after DONE while pulsing in_valid with sum=0x3 -> out_acc stays 248, beat_cnt=8, nothing accepted; out_ready=1 -> next cycle ACCUM, acc=0, in_ready=1.
4. Overflow (ACC_W=7): 8 beats of 31 -> without macro out_acc=120, out_ovf=1; with SUM_ACC_SATURATE_EN out_acc=127, out_ovf=1.
5. clr collision: after beats 5,7,9, assert clr with in_valid=1 (sum=0x4) -> beat dropped, beat_cnt=0; then 8 beats of 2 -> out_acc=16, out_ovf=0.
6. BEATS=1 with mixed values: beats 0, 31, 16 with out_ready=1 -> out_acc sequence 0, 31, 16, each frame taking 2 cycles (accept, then DONE handshake).
